// File: rtl/bus_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arb2                                                             |
// | Two-requester round-robin arbiter with locked tenures, a hold limit  |
// | and an integrated output data select.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bus_arb2 #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             lock_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic             lock_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] C_MAX_HOLD = CW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_prio, w_prio_nxt;
  logic            r_sel, w_sel_nxt;
  logic [CW-1:0]   r_hold_cnt, w_hold_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_accept;
  logic            w_release;
  logic            w_rearb;
  logic            w_pick_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_sel      <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_sel      <= w_sel_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign w_cnt_inc = r_hold_cnt + CW'(1);
  assign w_accept  = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold_cnt;
    w_release   = 1'b0;
    w_rearb     = 1'b0;
    w_pick_b    = 1'b0;

    case (r_state)
      IDLE: w_rearb = 1'b1;
      OWN_A: begin
        if (!req_a) begin
          w_release = 1'b1;
        end else if (w_accept) begin
          if (!lock_a || (w_cnt_inc == C_MAX_HOLD)) w_release = 1'b1;
          else w_hold_nxt = w_cnt_inc;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          w_release = 1'b1;
        end else if (w_accept) begin
          if (!lock_b || (w_cnt_inc == C_MAX_HOLD)) w_release = 1'b1;
          else w_hold_nxt = w_cnt_inc;
        end
      end
      default: w_rearb = 1'b1;
    endcase

    if (w_release) begin
      w_rearb     = 1'b1;
      w_hold_nxt  = '0;
      w_state_nxt = IDLE;
    end

    // On contention a releasing owner always yields to the other side.
    if (w_rearb) begin
      if (req_a && req_b) begin
        if (r_state == OWN_A)      w_pick_b = 1'b1;
        else if (r_state == OWN_B) w_pick_b = 1'b0;
        else                       w_pick_b = r_prio;
      end else begin
        w_pick_b = req_b;
      end

      if (req_a || req_b) begin
        w_state_nxt = w_pick_b ? OWN_B : OWN_A;
        w_sel_nxt   = w_pick_b;
        w_prio_nxt  = ~w_pick_b;
        w_hold_nxt  = '0;
      end
    end
  end

  assign gnt_a     = (r_state == OWN_A);
  assign gnt_b     = (r_state == OWN_B);
  assign out_sel   = r_sel;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign out_data  = r_sel ? data_b : data_a;

endmodule
`default_nettype wire

// File: tb/tb_bus_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_arb2                                                          |
// | Self-checking bench for bus_arb2 against a tenure-level model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bus_arb2;

  localparam int W  = 32;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a, lock_a, req_b, lock_b, out_ready;
  logic [W-1:0] data_a, data_b;
  logic         gnt_a, gnt_b, out_valid, out_sel;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner 0=none 1=A 2=B, first = side favoured from idle.
  int   m_owner;
  int   m_first;
  int   m_beats;
  logic m_sel;

  logic obs_acc_a, obs_acc_b, obs_sel, obs_gnt_a;

  bus_arb2 #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .lock_a    (lock_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .lock_b    (lock_b),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_first = 0;
    m_beats = 0;
    m_sel   = 1'b0;
  endtask

  task automatic model_step();
    int cur, pick;
    bit rel;
    cur = m_owner;
    rel = 0;
    pick = 0;
    if (cur == 1) begin
      if (!req_a) rel = 1;
      else if (out_ready) begin
        m_beats++;
        if (!lock_a || m_beats == MH) rel = 1;
      end
    end else if (cur == 2) begin
      if (!req_b) rel = 1;
      else if (out_ready) begin
        m_beats++;
        if (!lock_b || m_beats == MH) rel = 1;
      end
    end
    if (cur == 0 || rel) begin
      m_beats = 0;
      if (req_a && req_b) begin
        if (cur == 1)      pick = 2;
        else if (cur == 2) pick = 1;
        else               pick = (m_first == 0) ? 1 : 2;
      end else if (req_a) pick = 1;
      else if (req_b)     pick = 2;
      m_owner = pick;
      if (pick != 0) begin
        m_sel   = (pick == 2);
        m_first = (pick == 1) ? 1 : 0;
      end
    end
  endtask

  task automatic drive(input logic ra, input logic la, input logic rb, input logic lb,
                       input logic rdy, input logic [W-1:0] da, input logic [W-1:0] db);
    logic ev;
    @(negedge clk);
    req_a = ra; lock_a = la; req_b = rb; lock_b = lb; out_ready = rdy;
    data_a = da; data_b = db;
    #1;
    ev = (m_owner == 1 && ra) || (m_owner == 2 && rb);
    check_eq("gnt_a", gnt_a, (m_owner == 1));
    check_eq("gnt_b", gnt_b, (m_owner == 2));
    check_eq("out_sel", out_sel, m_sel);
    check_eq("out_valid", out_valid, ev);
    check_eq("out_data", out_data, m_sel ? db : da);
    obs_acc_a = gnt_a & out_valid & out_ready;
    obs_acc_b = gnt_b & out_valid & out_ready;
    obs_sel   = out_sel;
    obs_gnt_a = gnt_a;
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_a = 0; lock_a = 0; req_b = 0; lock_b = 0; out_ready = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int na;
    bit seen_b;
    reset = 1'b0;
    req_a = 0; lock_a = 0; req_b = 0; lock_b = 0; out_ready = 0;
    data_a = '0; data_b = '0;
    model_reset();
    #1;
    check_eq("rst_gnt_a", gnt_a, 0);
    check_eq("rst_gnt_b", gnt_b, 0);
    check_eq("rst_sel", out_sel, 0);
    check_eq("rst_valid", out_valid, 0);
    do_reset();

    // Single requester, one unlocked beat, then withdraw.
    drive(1, 0, 0, 0, 1, 32'h1234_5678, 32'h0);
    drive(1, 0, 0, 0, 1, 32'h1234_5678, 32'h0);
    check_eq("single_acc", obs_acc_a, 1);
    drive(0, 0, 0, 0, 1, 32'h1234_5678, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h1234_5678, 32'h0);
    check_eq("single_drop", obs_gnt_a, 0);

    // Both requesting unlocked from reset: A,B,A,B.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 1, 0, 1, 32'hAAAA_0000 + i, 32'hBBBB_0000 + i);
      if (i >= 2) check_eq("alt_sel", obs_sel, (i % 2 == 1));
    end
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);

    // Locked burst from A hits the hold limit, B is served next.
    drive(1, 1, 0, 0, 1, 32'hA0, 32'hB0);
    na = 0;
    seen_b = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 0, 1, 32'hA1 + i, 32'hB1 + i);
      if (obs_acc_b) seen_b = 1;
      if (!seen_b && obs_acc_a) na++;
    end
    check_eq("burst_len", na, MH);
    check_eq("b_served", seen_b, 1);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);

    // Backpressure: 5 stalled cycles then one acceptance.
    drive(1, 0, 0, 0, 0, 32'hC0DE, 32'h0);
    na = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, (i == 5), 32'hC0DE, 32'h0);
      check_eq("bp_gnt", obs_gnt_a, 1);
      if (obs_acc_a) na++;
    end
    check_eq("bp_accepts", na, 1);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);

    // Owner withdrawal: locked B drops req while A waits.
    drive(0, 0, 1, 1, 0, 32'h0, 32'hBEEF);
    drive(1, 0, 1, 1, 0, 32'hFACE, 32'hBEEF);
    drive(1, 0, 0, 1, 0, 32'hFACE, 32'hBEEF);
    check_eq("wd_no_acc", obs_acc_b, 0);
    drive(1, 0, 0, 0, 0, 32'hFACE, 32'h0);
    check_eq("wd_gnt_a", obs_gnt_a, 1);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h0);

    // Asynchronous reset in the middle of a B tenure.
    drive(0, 0, 1, 1, 0, 32'h0, 32'h5555);
    drive(0, 0, 1, 1, 0, 32'h0, 32'h5555);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_gnt_b", gnt_b, 0);
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_sel", out_sel, 0);
    model_reset();
    req_a = 0; req_b = 0; lock_a = 0; lock_b = 0;
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 1, 0, 1, 32'h11, 32'h22);
    drive(1, 0, 1, 0, 1, 32'h11, 32'h22);
    check_eq("arst_prio", obs_gnt_a, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
